// File: rtl/rob_cdb_pkg.sv
// Shared sizing and entry layout for the reorder buffer / common data bus slice.
package rob_cdb_pkg;

  localparam int TAG_W     = 4;
  localparam int ROB_DEPTH = 1 << TAG_W;
  localparam int XLEN      = 32;
  localparam int CNT_W     = TAG_W + 1;
  localparam int RD_W      = 5;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            has_rd;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] val;
  } rob_entry_t;

endpackage

// File: rtl/rob_wb_arb.sv
// Writeback arbiter: the ALU always wins the CDB; the LSB only gets through on idle ALU cycles.
module rob_wb_arb
  import rob_cdb_pkg::*;
(
  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [XLEN-1:0]  alu_val,
  input  logic             lsb_valid,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [XLEN-1:0]  lsb_val,
  output logic             win_valid,
  output logic [TAG_W-1:0] win_tag,
  output logic [XLEN-1:0]  win_val,
  output logic             lsb_accept
);

  always_comb begin
    win_valid  = alu_valid | lsb_valid;
    win_tag    = alu_valid ? alu_tag : lsb_tag;
    win_val    = alu_valid ? alu_val : lsb_val;
    lsb_accept = lsb_valid & ~alu_valid;
  end

endmodule

// File: rtl/rob_cdb.sv
// 16-entry reorder buffer driving the common data bus and in-order retirement.
// Optional ROB_FLUSH_EN adds a synchronous flush_in that empties the buffer.
module rob_cdb
  import rob_cdb_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_n_in,
`ifdef ROB_FLUSH_EN
  input  logic             flush_in,
`endif
  input  logic             iss_valid,
  input  logic             iss_has_rd,
  input  logic [RD_W-1:0]  iss_rd,
  output logic             iss_ready,
  output logic [TAG_W-1:0] iss_tag,
  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [XLEN-1:0]  alu_val,
  input  logic             lsb_valid,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [XLEN-1:0]  lsb_val,
  output logic             lsb_accept,
  output logic             cdb_flag,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_val,
  input  logic [TAG_W-1:0] qry1_tag,
  input  logic [TAG_W-1:0] qry2_tag,
  output logic             qry1_ready,
  output logic             qry2_ready,
  output logic [XLEN-1:0]  qry1_val,
  output logic [XLEN-1:0]  qry2_val,
  output logic             com_valid,
  output logic             com_has_rd,
  output logic [RD_W-1:0]  com_rd,
  output logic [TAG_W-1:0] com_tag,
  output logic [XLEN-1:0]  com_val
);

  rob_entry_t       entries [ROB_DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             win_valid;
  logic [TAG_W-1:0] win_tag;
  logic [XLEN-1:0]  win_val;
  logic             issue_fire;
  logic             wb_fire;
  logic             commit_fire;
  rob_entry_t       head_entry;

  rob_wb_arb u_arb (
    .alu_valid  (alu_valid),
    .alu_tag    (alu_tag),
    .alu_val    (alu_val),
    .lsb_valid  (lsb_valid),
    .lsb_tag    (lsb_tag),
    .lsb_val    (lsb_val),
    .win_valid  (win_valid),
    .win_tag    (win_tag),
    .win_val    (win_val),
    .lsb_accept (lsb_accept)
  );

  // No full-bypass: a same-cycle commit does not free a slot for issue.
  assign iss_ready   = count < CNT_W'(ROB_DEPTH);
  assign iss_tag     = tail;
  assign issue_fire  = iss_valid & iss_ready;
  assign wb_fire     = win_valid & entries[win_tag].busy & ~entries[win_tag].done;
  assign head_entry  = entries[head];
  assign commit_fire = head_entry.busy & head_entry.done;

  assign qry1_ready = entries[qry1_tag].busy & entries[qry1_tag].done;
  assign qry2_ready = entries[qry2_tag].busy & entries[qry2_tag].done;
  assign qry1_val   = entries[qry1_tag].val;
  assign qry2_val   = entries[qry2_tag].val;

  // Issue, writeback and commit always touch distinct entries on one edge:
  // the tail is free, the writeback target is not done, the head is done.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      cdb_flag   <= 1'b0;
      cdb_tag    <= '0;
      cdb_val    <= '0;
      com_valid  <= 1'b0;
      com_has_rd <= 1'b0;
      com_rd     <= '0;
      com_tag    <= '0;
      com_val    <= '0;
    end
`ifdef ROB_FLUSH_EN
    else if (flush_in) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      cdb_flag  <= 1'b0;
      com_valid <= 1'b0;
    end
`endif
    else begin
      if (issue_fire) begin
        entries[tail] <= '{busy: 1'b1, done: 1'b0, has_rd: iss_has_rd, rd: iss_rd, val: '0};
        tail          <= tail + 1'b1;
      end

      cdb_flag <= wb_fire;
      if (wb_fire) begin
        entries[win_tag].val  <= win_val;
        entries[win_tag].done <= 1'b1;
        cdb_tag               <= win_tag;
        cdb_val               <= win_val;
      end

      com_valid <= commit_fire;
      if (commit_fire) begin
        com_has_rd    <= head_entry.has_rd;
        com_rd        <= head_entry.rd;
        com_tag       <= head;
        com_val       <= head_entry.val;
        entries[head] <= '0;
        head          <= head + 1'b1;
      end

      count <= count + CNT_W'(issue_fire) - CNT_W'(commit_fire);
    end
  end

endmodule

// File: tb/tb_rob_cdb.sv
// Randomized self-checking bench for rob_cdb against a program-order queue model.
module tb_rob_cdb;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
`ifdef ROB_FLUSH_EN
  logic        flush_in = 1'b0;
`endif
  logic        iss_valid = 1'b0, iss_has_rd = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        iss_ready;
  logic [3:0]  iss_tag;
  logic        alu_valid = 1'b0, lsb_valid = 1'b0;
  logic [3:0]  alu_tag = '0, lsb_tag = '0;
  logic [31:0] alu_val = '0, lsb_val = '0;
  logic        lsb_accept;
  logic        cdb_flag;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic [3:0]  qry1_tag = '0, qry2_tag = '0;
  logic        qry1_ready, qry2_ready;
  logic [31:0] qry1_val, qry2_val;
  logic        com_valid, com_has_rd;
  logic [4:0]  com_rd;
  logic [3:0]  com_tag;
  logic [31:0] com_val;

  rob_cdb dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
`ifdef ROB_FLUSH_EN
    .flush_in   (flush_in),
`endif
    .iss_valid  (iss_valid),
    .iss_has_rd (iss_has_rd),
    .iss_rd     (iss_rd),
    .iss_ready  (iss_ready),
    .iss_tag    (iss_tag),
    .alu_valid  (alu_valid),
    .alu_tag    (alu_tag),
    .alu_val    (alu_val),
    .lsb_valid  (lsb_valid),
    .lsb_tag    (lsb_tag),
    .lsb_val    (lsb_val),
    .lsb_accept (lsb_accept),
    .cdb_flag   (cdb_flag),
    .cdb_tag    (cdb_tag),
    .cdb_val    (cdb_val),
    .qry1_tag   (qry1_tag),
    .qry2_tag   (qry2_tag),
    .qry1_ready (qry1_ready),
    .qry2_ready (qry2_ready),
    .qry1_val   (qry1_val),
    .qry2_val   (qry2_val),
    .com_valid  (com_valid),
    .com_has_rd (com_has_rd),
    .com_rd     (com_rd),
    .com_tag    (com_tag),
    .com_val    (com_val)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  tag;
    bit          has_rd;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] val;
  } ent_t;

  ent_t        q[$];
  logic [3:0]  next_tag;
  bit          exp_cdb_flag, exp_com_valid, exp_com_has_rd;
  logic [3:0]  exp_cdb_tag, exp_com_tag;
  logic [31:0] exp_cdb_val, exp_com_val;
  logic [4:0]  exp_com_rd;
  int          checks = 0;
  int          errors = 0;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_query(input logic [3:0] t, output bit r, output logic [31:0] v);
    r = 1'b0;
    v = '0;
    foreach (q[i]) if (q[i].tag == t && q[i].done) begin
      r = 1'b1;
      v = q[i].val;
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    next_tag = '0;
    exp_cdb_flag = 1'b0;
    exp_com_valid = 1'b0;
  endfunction

  // Program-order view: in-flight instructions live in a queue, oldest first.
  function automatic void model_edge();
    bit          do_commit, hit;
    logic [3:0]  wt;
    logic [31:0] wv;
    ent_t        f;
`ifdef ROB_FLUSH_EN
    if (flush_in) begin
      model_reset();
      return;
    end
`endif
    do_commit = q.size() > 0 && q[0].done;
    hit = 1'b0;
    if (alu_valid || lsb_valid) begin
      wt = alu_valid ? alu_tag : lsb_tag;
      wv = alu_valid ? alu_val : lsb_val;
      foreach (q[i]) if (q[i].tag == wt && !q[i].done) begin
        q[i].done = 1'b1;
        q[i].val = wv;
        hit = 1'b1;
      end
      if (hit) begin
        exp_cdb_tag = wt;
        exp_cdb_val = wv;
      end
    end
    exp_cdb_flag = hit;
    if (iss_valid && q.size() < 16) begin
      q.push_back('{tag: next_tag, has_rd: iss_has_rd, rd: iss_rd, done: 1'b0, val: '0});
      next_tag = next_tag + 4'd1;
    end
    exp_com_valid = do_commit;
    if (do_commit) begin
      f = q.pop_front();
      exp_com_tag = f.tag;
      exp_com_has_rd = f.has_rd;
      exp_com_rd = f.rd;
      exp_com_val = f.val;
    end
  endfunction

  task automatic run_cycle();
    bit          r;
    logic [31:0] v;
    #1;
    check_output("iss_ready", iss_ready, q.size() < 16);
    check_output("iss_tag", iss_tag, next_tag);
    check_output("lsb_accept", lsb_accept, lsb_valid && !alu_valid);
    model_query(qry1_tag, r, v);
    check_output("qry1_ready", qry1_ready, r);
    if (r) check_output("qry1_val", qry1_val, v);
    model_query(qry2_tag, r, v);
    check_output("qry2_ready", qry2_ready, r);
    if (r) check_output("qry2_val", qry2_val, v);
    model_edge();
    @(posedge clk_in);
    #1;
    check_output("cdb_flag", cdb_flag, exp_cdb_flag);
    if (exp_cdb_flag) begin
      check_output("cdb_tag", cdb_tag, exp_cdb_tag);
      check_output("cdb_val", cdb_val, exp_cdb_val);
    end
    check_output("com_valid", com_valid, exp_com_valid);
    if (exp_com_valid) begin
      check_output("com_tag", com_tag, exp_com_tag);
      check_output("com_has_rd", com_has_rd, exp_com_has_rd);
      check_output("com_rd", com_rd, exp_com_rd);
      check_output("com_val", com_val, exp_com_val);
    end
  endtask

  task automatic apply_stimulus(input bit iv, input bit hrd, input logic [4:0] rd,
                                input bit av, input logic [3:0] at, input logic [31:0] aval,
                                input bit lv, input logic [3:0] lt, input logic [31:0] lval);
    iss_valid = iv;  iss_has_rd = hrd; iss_rd = rd;
    alu_valid = av;  alu_tag = at;     alu_val = aval;
    lsb_valid = lv;  lsb_tag = lt;     lsb_val = lval;
    qry1_tag = 4'($urandom);
    qry2_tag = (q.size() > 0) ? q[$urandom_range(q.size() - 1)].tag : 4'($urandom);
    run_cycle();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst_n_in = 1'b0;
    iss_valid = 1'b0; alu_valid = 1'b0; lsb_valid = 1'b0;
    #2;
    check_output("rst_cdb_flag", cdb_flag, 0);
    check_output("rst_cdb_tag", cdb_tag, 0);
    check_output("rst_cdb_val", cdb_val, 0);
    check_output("rst_com_valid", com_valid, 0);
    check_output("rst_com_fields", {com_has_rd, com_rd, com_tag, com_val}, 0);
    check_output("rst_iss_tag", iss_tag, 0);
    check_output("rst_iss_ready", iss_ready, 1);
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  initial begin
    do_reset();

    for (int i = 0; i < 17; i++) apply_stimulus(1, 1, 5'(i + 1), 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 5'd3, 0, 0, 0, 0, 0, 0);
    do_reset();

    apply_stimulus(1, 1, 5'd5, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 4'd0, 32'hDEADBEEF, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    for (int i = 0; i < 4; i++) apply_stimulus(1, 1, 5'(i + 8), 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 4'd2, 32'h11, 1, 4'd3, 32'h22);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 4'd3, 32'h22);
    apply_stimulus(0, 0, 0, 1, 4'd1, 32'h33, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 4'd0, 32'h44);
    for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      logic [3:0] at, lt;
      at = (q.size() > 0 && $urandom_range(3) != 0) ? q[$urandom_range(q.size() - 1)].tag : 4'($urandom);
      lt = (q.size() > 0 && $urandom_range(3) != 0) ? q[$urandom_range(q.size() - 1)].tag : 4'($urandom);
      apply_stimulus($urandom_range(9) < 6, 1'($urandom), 5'($urandom),
                     $urandom_range(2) == 0, at, $urandom,
                     $urandom_range(2) == 0, lt, $urandom);
    end

    do_reset();
    for (int i = 0; i < 5; i++) apply_stimulus(1, 1, 5'(i + 20), 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 4'd0, 32'h55, 0, 0, 0);
    #2;
    do_reset();
    apply_stimulus(1, 1, 5'd9, 0, 0, 0, 0, 0, 0);

`ifdef ROB_FLUSH_EN
    for (int i = 0; i < 5; i++) apply_stimulus(1, 1, 5'(i + 1), 0, 0, 0, 0, 0, 0);
    flush_in = 1'b1;
    apply_stimulus(1, 1, 5'd7, 1, 4'd2, 32'h77, 0, 0, 0);
    flush_in = 1'b0;
    apply_stimulus(1, 1, 5'd7, 0, 0, 0, 0, 0, 0);
`endif

    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
